// File: rtl/aes_dec_round_sched.sv
// aes_dec_round_sched: sequences ARK/ISR/ISB/IMC sub-blocks through the AES inverse cipher (Nr = 10/12/14).
// Ports:
//   ap_clk, ap_rst_n               clock, asynchronous active-low reset
//   ap_start, nr                   run request and round count (latched in IDLE)
//   ap_done, ap_ready, ap_idle     ap_ctrl_hs status towards the caller
//   err                            latched nr was not 10/12/14
//   ark_start/ark_done, ark_n      AddRoundKey handshake and round index
//   isr_start/isr_done             InvShiftRow handshake
//   isb_start/isb_done             InvByteSub handshake
//   imc_start/imc_done             InvMixColumn handshake
//   statemt_sel                    statemt owner: 0 none, 1 ARK, 2 ISR, 3 ISB, 4 IMC
module aes_dec_round_sched #(
  parameter int RW = 5
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          ap_start,
  input  logic [3:0]    nr,
  output logic          ap_done,
  output logic          ap_ready,
  output logic          ap_idle,
  output logic          err,
  output logic          ark_start,
  input  logic          ark_done,
  output logic [RW-1:0] ark_n,
  output logic          isr_start,
  input  logic          isr_done,
  output logic          isb_start,
  input  logic          isb_done,
  output logic          imc_start,
  input  logic          imc_done,
  output logic [2:0]    statemt_sel
);
  typedef enum logic [2:0] {IDLE, ARK0, ISR, ISB, ARK, IMC, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] rnd, nr_q;
  logic legal;
  assign legal = nr == 4'd10 || nr == 4'd12 || nr == 4'd14;
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      rnd  <= '0;
      nr_q <= '0;
      err  <= 1'b0;
    end else begin
      if (state == IDLE && ap_start) begin
        nr_q <= nr;
        err  <= !legal;
      end
      if (state == ARK0 && ark_done) rnd <= nr_q - 4'd1;
      if (state == IMC && imc_done) rnd <= rnd - 4'd1;
    end
  // each state only looks at its own done, so idle sub-blocks holding done high are ignored
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (ap_start) state_nx = legal ? ARK0 : DONE;
      ARK0: if (ark_done) state_nx = ISR;
      ISR:  if (isr_done) state_nx = ISB;
      ISB:  if (isb_done) state_nx = ARK;
      ARK:  if (ark_done) state_nx = rnd == 4'd0 ? DONE : IMC;
      IMC:  if (imc_done) state_nx = ISR;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    ark_start   = state == ARK0 || state == ARK;
    isr_start   = state == ISR;
    isb_start   = state == ISB;
    imc_start   = state == IMC;
    statemt_sel = ark_start ? 3'd1 : isr_start ? 3'd2 : isb_start ? 3'd3 : imc_start ? 3'd4 : 3'd0;
    ark_n       = state == ARK0 ? RW'(nr_q) : state == ARK ? RW'(rnd) : '0;
    ap_done     = state == DONE;
    ap_ready    = state == DONE;
    ap_idle     = state == IDLE && !ap_start;
  end
endmodule

// File: tb/tb_aes_dec_round_sched.sv
// tb_aes_dec_round_sched: scoreboard bench for aes_dec_round_sched with latency-programmable sub-block stubs.
module tb_aes_dec_round_sched;
  localparam int RW = 5;
  logic ap_clk = 1'b0, ap_rst_n = 1'b1, ap_start = 1'b0;
  logic [3:0] nr = 4'd0;
  logic ap_done, ap_ready, ap_idle, err;
  logic ark_start, ark_done, isr_start, isr_done, isb_start, isb_done, imc_start, imc_done;
  logic [RW-1:0] ark_n;
  logic [2:0] statemt_sel;
  logic [3:0] spur = 4'd0;
  logic stub_done = 1'b0;
  aes_dec_round_sched #(.RW(RW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .nr(nr),
    .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle), .err(err),
    .ark_start(ark_start), .ark_done(ark_done), .ark_n(ark_n),
    .isr_start(isr_start), .isr_done(isr_done),
    .isb_start(isb_start), .isb_done(isb_done),
    .imc_start(imc_start), .imc_done(imc_done),
    .statemt_sel(statemt_sel)
  );
  always #5 ap_clk = ~ap_clk;
  assign ark_done = (ark_start & stub_done) | spur[0];
  assign isr_done = (isr_start & stub_done) | spur[1];
  assign isb_done = (isb_start & stub_done) | spur[2];
  assign imc_done = (imc_start & stub_done) | spur[3];
  typedef struct {int unit; int n;} op_t;
  typedef struct {bit err; int cyc; int ops;} run_t;
  op_t  exp_q[$];
  run_t run_q[$];
  int   lat_q[$];
  int checks = 0, errors = 0;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask
  // Reference op order: ARK(n), then groups {ISR, ISB, ARK(r), IMC} for r = n-1..1, then ISR, ISB, ARK(0).
  function automatic void plan(input int n, input int lmin, input int lmax, input bit imc1);
    int sum, g, j, u, rn, lt;
    if (!(n == 10 || n == 12 || n == 14)) begin
      run_q.push_back('{1'b1, 1, 0});
      return;
    end
    sum = 0;
    for (int k = 0; k < 4 * n; k++) begin
      g  = (k - 1) / 4;
      j  = (k - 1) % 4;
      u  = k == 0 ? 1 : j == 0 ? 2 : j == 1 ? 3 : j == 2 ? 1 : 4;
      rn = k == 0 ? n : j == 2 ? n - 1 - g : 0;
      lt = (u == 4 && imc1) ? 1 : int'($urandom_range(lmax, lmin));
      exp_q.push_back('{u, rn});
      lat_q.push_back(lt);
      sum += lt;
    end
    run_q.push_back('{1'b0, 1 + sum, 4 * n});
  endfunction
  // Monitor: per-cycle protocol checks, op order and completion checks against the queues.
  logic p_act = 1'b0, p_done = 1'b0, m_act, m_done;
  int cyc = 0, ops = 0, obs;
  op_t  e_op;
  run_t e_run;
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      p_act = 1'b0;
      p_done = 1'b0;
      cyc = 0;
      ops = 0;
    end else begin
      cyc++;
      obs = ark_start ? 1 : isr_start ? 2 : isb_start ? 3 : imc_start ? 4 : 0;
      m_act = obs != 0;
      m_done = (ark_start & ark_done) | (isr_start & isr_done) | (isb_start & isb_done) | (imc_start & imc_done);
      chk("one_start", int'($countones({ark_start, isr_start, isb_start, imc_start}) <= 1), 1);
      chk("statemt_sel", statemt_sel, obs);
      chk("ap_ready", ap_ready, ap_done);
      chk("ap_idle", ap_idle, !m_act && !ap_done && !ap_start);
      if (m_act && (!p_act || p_done)) begin
        ops++;
        if (exp_q.size() == 0) chk("unexpected_op", obs, 0);
        else begin
          e_op = exp_q.pop_front();
          chk("op_unit", obs, e_op.unit);
          if (e_op.unit == 1) chk("ark_n", ark_n, e_op.n);
        end
      end
      if (ap_done) begin
        if (run_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e_run = run_q.pop_front();
          chk("done_cycle", cyc, e_run.cyc);
          chk("err", err, e_run.err);
          chk("op_count", ops, e_run.ops);
        end
      end
      if (!m_act && !ap_done && ap_start) begin
        cyc = 0;
        ops = 0;
      end
      p_act = m_act;
      p_done = m_done;
    end
  end
  // Stub: one shared sub-block model; each new op takes its latency from lat_q.
  int s_cnt = 0, s_lat = 1;
  logic s_act;
  always @(posedge ap_clk) begin
    #1;
    if (!ap_rst_n) stub_done = 1'b0;
    else begin
      s_act = ark_start | isr_start | isb_start | imc_start;
      if (s_act && (!p_act || p_done)) begin
        s_cnt = 1;
        s_lat = lat_q.size() != 0 ? lat_q.pop_front() : 1;
      end else if (s_act) s_cnt++;
      stub_done = s_act && s_cnt >= s_lat;
    end
  end
  task automatic start(input int n);
    @(posedge ap_clk);
    #2;
    nr = 4'(n);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #2;
    ap_start = 1'b0;
    nr = 4'($urandom);
  endtask
  task automatic wait_done(input bit pulse);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge ap_clk);
      if (ap_done) seen = 1'b1;
      if (pulse) spur[0] = isr_start && !spur[0];
    end
    spur[0] = 1'b0;
    chk("done_timeout", int'(seen), 1);
  endtask
  initial begin
    int k;
    ap_rst_n = 1'b0;
    #1;
    chk("rst_starts", {ark_start, isr_start, isb_start, imc_start}, 0);
    chk("rst_sel", statemt_sel, 0);
    chk("rst_done_err", {ap_done, ap_ready, err}, 0);
    chk("rst_idle", ap_idle, 1);
    repeat (2) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    plan(10, 1, 1, 1'b0);
    start(10);
    k = 0;
    for (int i = 0; i < 200 && k < 5; i++) begin
      @(negedge ap_clk);
      if (isb_start) k++;
    end
    chk("reach_isb_rnd5", k, 5);
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_starts", {ark_start, isr_start, isb_start, imc_start}, 0);
    chk("midrst_sel", statemt_sel, 0);
    chk("midrst_done_err", {ap_done, ap_ready, err}, 0);
    chk("midrst_ark_n", ark_n, 0);
    chk("midrst_idle", ap_idle, 1);
    exp_q.delete();
    run_q.delete();
    lat_q.delete();
    repeat (2) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("post_rst_idle", ap_idle, 1);
    chk("post_rst_starts", {ark_start, isr_start, isb_start, imc_start}, 0);
    plan(10, 1, 1, 1'b0);
    start(10);
    wait_done(1'b0);
    plan(14, 1, 20, 1'b0);
    start(14);
    wait_done(1'b0);
    spur[3] = 1'b1;
    plan(10, 1, 4, 1'b1);
    start(10);
    wait_done(1'b1);
    spur[3] = 1'b0;
    plan(11, 1, 1, 1'b0);
    start(11);
    wait_done(1'b0);
    @(negedge ap_clk);
    chk("err_held", err, 1);
    plan(12, 1, 3, 1'b0);
    start(12);
    wait_done(1'b0);
    plan(10, 1, 3, 1'b0);
    plan(14, 1, 3, 1'b0);
    @(posedge ap_clk);
    #2;
    nr = 4'd10;
    ap_start = 1'b1;
    repeat (5) @(posedge ap_clk);
    #2;
    nr = 4'd14;
    wait_done(1'b0);
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_start = 1'b0;
    wait_done(1'b0);
    repeat (4) @(negedge ap_clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("run_q_drained", run_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
